// File: rtl/ac97_frame_tx_if.sv
// Command request channel into the AC'97 frame transmitter.
interface ac97_frame_tx_if;
    // valid/ready: a command transfers on a rising clk edge where cmd_valid and cmd_ready
    // are both high; the master keeps cmd_valid, cmd_addr and cmd_data stable until then.
    logic        cmd_valid;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/ac97_frame_tx.sv
// AC'97-style 256-bit frame serializer: tag, optional codec register write, mono PCM on
// both stereo slots, with a one-entry command holding register and a 48 kHz frame strobe.
module ac97_frame_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    sample_in,
    output logic           new_frame,
    ac97_frame_tx_if.slave cmd,
    output logic           sync,
    output logic           sdata_out
);
    localparam int               SUB_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       TAG_BITS    = 8'd16;

    logic [SUB_W-1:0] sub_cnt;
    logic [7:0]       bit_cnt;

    // cmd_ready_q high means the holding register is empty
    logic             cmd_ready_q;
    logic [6:0]       hold_addr;
    logic [15:0]      hold_data;

    logic             cmd_loaded;
    logic [6:0]       frame_addr;
    logic [15:0]      frame_data;
    logic [15:0]      captured_sample;

    logic             frame_start;
    logic             capture;
    logic             accept;
    logic [15:0]      tag;
    logic [19:0]      slot1;
    logic [19:0]      slot2;
    logic [19:0]      slot_pcm;
    logic [255:0]     frame_vec;

    assign frame_start   = (bit_cnt == 8'd0) && (sub_cnt == '0);
    assign capture       = (bit_cnt == TAG_BITS) && (sub_cnt == '0);
    assign accept        = cmd.cmd_valid && cmd_ready_q;
    assign cmd.cmd_ready = cmd_ready_q;

    // Frame bit b lives at frame_vec[255-b]; slots 5..12 are always zero.
    assign tag       = {1'b1, cmd_loaded, cmd_loaded, 2'b11, 11'd0};
    assign slot1     = cmd_loaded ? {1'b0, frame_addr, 12'h000} : 20'd0;
    assign slot2     = cmd_loaded ? {frame_data, 4'h0} : 20'd0;
    assign slot_pcm  = {captured_sample, 4'h0};
    assign frame_vec = {tag, slot1, slot2, slot_pcm, slot_pcm, 160'd0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_cnt         <= '0;
            bit_cnt         <= 8'd0;
            cmd_ready_q     <= 1'b1;
            hold_addr       <= 7'd0;
            hold_data       <= 16'd0;
            cmd_loaded      <= 1'b0;
            frame_addr      <= 7'd0;
            frame_data      <= 16'd0;
            captured_sample <= 16'd0;
            new_frame       <= 1'b0;
            sync            <= 1'b0;
            sdata_out       <= 1'b0;
        end else begin
            if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                bit_cnt <= bit_cnt + 8'd1;
            end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
            end

            new_frame <= frame_start;
            sync      <= (bit_cnt < TAG_BITS);
            sdata_out <= frame_vec[8'd255 - bit_cnt];

            if (capture) begin
                captured_sample <= sample_in;
            end

            if (frame_start) begin
                cmd_loaded <= ~cmd_ready_q;
                if (!cmd_ready_q) begin
                    frame_addr <= hold_addr;
                    frame_data <= hold_data;
                end
            end

            // A full holding register blocks accept, so draining and filling never collide.
            if (frame_start && !cmd_ready_q) begin
                cmd_ready_q <= 1'b1;
            end else if (accept) begin
                cmd_ready_q <= 1'b0;
                hold_addr   <= cmd.cmd_addr;
                hold_data   <= cmd.cmd_data;
            end
        end
    end
endmodule

// File: tb/tb_ac97_frame_tx.sv
// Bench for ac97_frame_tx: per-cycle comparison against a frame-level model plus
// hand-computed literal expectations for reset, timing boundaries and decoded frames.
module tb_ac97_frame_tx;
    localparam int CPB     = 2;
    localparam int FRAME   = 256 * CPB;
    localparam int CAP_POS = 16 * CPB;
    localparam int NFR     = 9;

    localparam logic [15:0] E_TAG [NFR] = '{16'h9800, 16'h9800, 16'hF800, 16'h9800, 16'h9800,
                                            16'hF800, 16'hF800, 16'h9800, 16'h9800};
    localparam logic [19:0] E_S1 [NFR]  = '{20'h0, 20'h0, 20'h02000, 20'h0, 20'h0,
                                            20'h02000, 20'h18000, 20'h0, 20'h0};
    localparam logic [19:0] E_S2 [NFR]  = '{20'h0, 20'h0, 20'h08080, 20'h0, 20'h0,
                                            20'h08080, 20'h0, 20'h0, 20'h0};
    localparam logic [19:0] E_PCM [NFR] = '{20'hA5C30, 20'hA5C30, 20'hA5C30, 20'h12340, 20'h7FFF0,
                                            20'h7FFF0, 20'h7FFF0, 20'h7FFF0, 20'h00000};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        new_frame;
    logic        sync;
    logic        sdata_out;

    ac97_frame_tx_if cmd_if ();

    ac97_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (rst),
        .sample_in (sample_in),
        .new_frame (new_frame),
        .cmd       (cmd_if),
        .sync      (sync),
        .sdata_out (sdata_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_prints = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } cmd_t;

    cmd_t        hold_q[$];
    int          m_cnt = -1;
    logic        m_loaded = 1'b0;
    logic [6:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    logic [15:0] m_sample = '0;

    function automatic logic exp_bit(input int b, input logic ld, input logic [6:0] a,
                                     input logic [15:0] d, input logic [15:0] s);
        logic [15:0] t;
        logic [19:0] w;
        int n;
        int p;
        t = {1'b1, ld, ld, 2'b11, 11'd0};
        if (b < 16) return t[15-b];
        n = (b - 16) / 20 + 1;
        p = (b - 16) % 20;
        case (n)
            1:       w = ld ? {1'b0, a, 12'h000} : 20'h0;
            2:       w = ld ? {d, 4'h0} : 20'h0;
            3, 4:    w = {s, 4'h0};
            default: w = 20'h0;
        endcase
        return w[19-p];
    endfunction

    always @(posedge clk) begin
        int   pos;
        logic acc;
        cmd_t c;
        if (rst) begin
            m_cnt    = -1;
            hold_q.delete();
            m_loaded = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_sample = '0;
        end else begin
            m_cnt++;
            pos = m_cnt % FRAME;
            acc = cmd_if.cmd_valid && (hold_q.size() == 0);
            if (pos == 0) begin
                if (hold_q.size() != 0) begin
                    c        = hold_q.pop_front();
                    m_loaded = 1'b1;
                    m_addr   = c.addr;
                    m_data   = c.data;
                end else begin
                    m_loaded = 1'b0;
                end
            end
            if (pos == CAP_POS) m_sample = sample_in;
            if (acc) hold_q.push_back({cmd_if.cmd_addr, cmd_if.cmd_data});
        end
    end

    // ---------------- scoreboard: per-cycle compare and frame collection ----------------
    logic [255:0] rx;
    logic [255:0] rx_q[$];

    always @(negedge clk) begin
        int   pos;
        logic e_nf, e_sy, e_sd, e_rd;
        if (rst || m_cnt < 0) begin
            e_nf = 1'b0; e_sy = 1'b0; e_sd = 1'b0; e_rd = 1'b1;
        end else begin
            pos  = m_cnt % FRAME;
            e_nf = (pos == 0);
            e_sy = (pos / CPB) < 16;
            e_sd = exp_bit(pos / CPB, m_loaded, m_addr, m_data, m_sample);
            e_rd = (hold_q.size() == 0);
            if (pos % CPB == 0) rx[255 - pos / CPB] = sdata_out;
            if (pos == FRAME - 1) rx_q.push_back(rx);
        end
        tests++;
        if ({new_frame, sync, sdata_out, cmd_if.cmd_ready} !== {e_nf, e_sy, e_sd, e_rd}) begin
            fails++;
            if (cyc_prints < 40) begin
                cyc_prints++;
                $display("FAIL cycle %0d new_frame/sync/sdata/ready: got %b%b%b%b expected %b%b%b%b",
                         m_cnt, new_frame, sync, sdata_out, cmd_if.cmd_ready, e_nf, e_sy, e_sd, e_rd);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_at(input int abs_cnt);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (m_cnt != abs_cnt && guard < 20000);
        if (m_cnt != abs_cnt) begin
            tests++;
            fails++;
            $display("FAIL wait_at: reached %0d expected %0d", m_cnt, abs_cnt);
        end
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic [6:0] a, input logic [15:0] d);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_addr  = a;
        cmd_if.cmd_data  = d;
    endtask

    task automatic check_reset_outputs(input string tag_name);
        check({tag_name, "_new_frame"}, new_frame, 1'b0);
        check({tag_name, "_sync"}, sync, 1'b0);
        check({tag_name, "_sdata"}, sdata_out, 1'b0);
        check({tag_name, "_ready"}, cmd_if.cmd_ready, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] f;
        rst       = 1'b1;
        sample_in = 16'hA5C3;
        drive_cmd(1'b0, 7'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #1;
        rst = 1'b0;

        // free-running frame timing
        wait_at(0);
        check("first_new_frame", new_frame, 1'b1);
        check("first_sync", sync, 1'b1);
        check("first_tag_bit", sdata_out, 1'b1);
        wait_at(1);
        check("new_frame_one_cycle", new_frame, 1'b0);
        wait_at(CAP_POS - 1);
        check("sync_last_cycle", sync, 1'b1);
        wait_at(CAP_POS);
        check("sync_falls", sync, 1'b0);

        // single command, accepted mid-frame 1
        wait_at(FRAME + 99);
        drive_cmd(1'b1, 7'h02, 16'h0808);
        wait_at(FRAME + 100);
        drive_cmd(1'b0, 7'h0, 16'h0);
        check("ready_drops", cmd_if.cmd_ready, 1'b0);
        wait_at(2 * FRAME - 1);
        check("ready_low_before_start", cmd_if.cmd_ready, 1'b0);
        wait_at(2 * FRAME);
        check("ready_rises_after_start", cmd_if.cmd_ready, 1'b1);
        check("new_frame_period", new_frame, 1'b1);

        // capture point in frame 3
        wait_at(3 * FRAME + CAP_POS - 1);
        sample_in = 16'h1234;
        wait_at(3 * FRAME + CAP_POS);
        sample_in = 16'h7FFF;

        // back-to-back commands
        wait_at(4 * FRAME + 199);
        drive_cmd(1'b1, 7'h02, 16'h0808);
        wait_at(4 * FRAME + 200);
        drive_cmd(1'b1, 7'h18, 16'h0000);
        wait_at(5 * FRAME);
        check("b2b_ready_after_start", cmd_if.cmd_ready, 1'b1);
        wait_at(5 * FRAME + 1);
        drive_cmd(1'b0, 7'h0, 16'h0);
        check("b2b_second_accepted", cmd_if.cmd_ready, 1'b0);

        // reset during slot 3 with a pending command
        wait_at(8 * FRAME + 49);
        drive_cmd(1'b1, 7'h10, 16'hBEEF);
        wait_at(8 * FRAME + 50);
        drive_cmd(1'b0, 7'h0, 16'h0);
        wait_at(8 * FRAME + 120);
        check("sdata_before_reset", sdata_out, 1'b1);
        check("ready_pending", cmd_if.cmd_ready, 1'b0);
        rst       = 1'b1;
        sample_in = 16'h0000;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        wait_at(0);
        check("restart_new_frame", new_frame, 1'b1);
        wait_at(FRAME + 4);

        // decoded frames against literal expectations
        check("frames_collected", rx_q.size(), NFR);
        for (int i = 0; i < NFR && i < rx_q.size(); i++) begin
            f = rx_q[i];
            check($sformatf("frame%0d_tag", i), f[255:240], E_TAG[i]);
            check($sformatf("frame%0d_slot1", i), f[239:220], E_S1[i]);
            check($sformatf("frame%0d_slot2", i), f[219:200], E_S2[i]);
            check($sformatf("frame%0d_slot3", i), f[199:180], E_PCM[i]);
            check($sformatf("frame%0d_slot4", i), f[179:160], E_PCM[i]);
            check($sformatf("frame%0d_slots5_12_zero", i), f[159:0] == 160'd0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
